// File: rtl/fp_addsub_seq.sv
// rtl/fp_addsub_seq.sv - multi-cycle IEEE-754-style floating-point adder/subtractor
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 op_sub,
  input  logic [EXP_W+MAN_W:0] dataA,
  input  logic [EXP_W+MAN_W:0] dataB,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] dataR,
  output logic                 flag_invalid,
  output logic                 flag_overflow,
  output logic                 flag_underflow,
  output logic                 flag_inexact
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 5;   // {carry, hidden, frac, G, R, S}
  localparam int EW = EXP_W + 1;   // one spare bit so exponent overflow is visible
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;   // b_q holds B with the effective sign
  logic          sign_q, sign_d, sub_q, sub_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [MW-1:0] big_q, big_d, small_q, small_d;
  logic [W-1:0]  res_q, res_d;
  logic          inv_q, inv_d, ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;
  logic          done_q, done_d, busy_q, busy_d;

  // Result staging for the transition into DONE
  logic          fin, fin_inv, fin_ovf, fin_unf, fin_inx;
  logic [W-1:0]  fin_res;

  // Operand unpack and classification
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign sa     = a_q[W-1];
  assign sb     = b_q[W-1];
  assign ea     = a_q[W-2:MAN_W];
  assign eb     = b_q[W-2:MAN_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);

  // Magnitude ordering: the larger operand fixes working exponent and sign
  logic               a_big, big_s;
  logic [EXP_W-1:0]   big_e, small_e, ediff;
  logic [MAN_W-1:0]   big_f, small_f;
  logic [MW-1:0]      small_m, small_sh;
  logic               small_lost;

  assign a_big      = a_q[W-2:0] >= b_q[W-2:0];
  assign big_s      = a_big ? sa : sb;
  assign big_e      = a_big ? ea : eb;
  assign small_e    = a_big ? eb : ea;
  assign big_f      = a_big ? fa : fb;
  assign small_f    = a_big ? fb : fa;
  assign ediff      = big_e - small_e;
  assign small_m    = {2'b01, small_f, 3'b000};
  assign small_sh   = small_m >> ediff;
  // Bits pushed below S collapse into the sticky bit
  assign small_lost = |(small_m & ~({MW{1'b1}} << ediff));

  // Add/subtract of aligned magnitudes (big >= small, so no sign flip)
  logic [MW-1:0] sum;
  assign sum = sub_q ? (big_q - small_q) : (big_q + small_q);

  // One-bit left normalisation step
  logic [EW-1:0] exp_dec;
  logic [MW-1:0] shl;
  assign exp_dec = exp_q - EW'(1);
  assign shl     = {big_q[MW-2:0], 1'b0};

  // Round to nearest even on the normalised word
  logic               g, r, s, lsb, inc, rovf;
  logic [MAN_W+1:0]   rsig;
  logic [MAN_W-1:0]   rfrac;
  logic [EW-1:0]      rexp;

  assign lsb   = big_q[3];
  assign g     = big_q[2];
  assign r     = big_q[1];
  assign s     = big_q[0];
  assign inc   = g & (r | s | lsb);
  assign rsig  = {1'b0, big_q[MW-2:3]} + {{(MAN_W+1){1'b0}}, inc};
  assign rfrac = rsig[MAN_W+1] ? rsig[MAN_W:1] : rsig[MAN_W-1:0];
  assign rexp  = exp_q + {{(EW-1){1'b0}}, rsig[MAN_W+1]};
  assign rovf  = rexp >= {1'b0, EXP_ONES};

  // Next-state, datapath and result selection
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    big_d   = big_q;
    small_d = small_q;
    res_d   = res_q;
    inv_d   = inv_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    inx_d   = inx_q;
    fin     = 1'b0;
    fin_res = '0;
    fin_inv = 1'b0;
    fin_ovf = 1'b0;
    fin_unf = 1'b0;
    fin_inx = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = dataA;
          b_d     = {dataB[W-1] ^ op_sub, dataB[W-2:0]};
          state_d = S_ALIGN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ALIGN: begin
        if (a_nan || b_nan) begin
          fin = 1'b1; fin_res = QNAN; fin_inv = 1'b1;
        end else if (a_inf && b_inf) begin
          fin = 1'b1;
          if (sa != sb) begin
            fin_res = QNAN; fin_inv = 1'b1;
          end else begin
            fin_res = a_q;
          end
        end else if (a_inf) begin
          fin = 1'b1; fin_res = a_q;
        end else if (b_inf) begin
          fin = 1'b1; fin_res = b_q;
        end else if (a_zero && b_zero) begin
          fin = 1'b1; fin_res = {sa & sb, {(W-1){1'b0}}};
        end else if (a_zero) begin
          fin = 1'b1; fin_res = b_q;
        end else if (b_zero) begin
          fin = 1'b1; fin_res = a_q;
        end else begin
          sign_d  = big_s;
          sub_d   = sa ^ sb;
          exp_d   = {1'b0, big_e};
          big_d   = {2'b01, big_f, 3'b000};
          small_d = {small_sh[MW-1:1], small_sh[0] | small_lost};
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (sum == '0) begin
          fin = 1'b1; fin_res = '0;
        end else begin
          big_d   = sum;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (big_q[MW-1]) begin
          big_d   = {1'b0, big_q[MW-1:2], big_q[1] | big_q[0]};
          exp_d   = exp_q + EW'(1);
          state_d = S_ROUND;
        end else if (big_q[MW-2]) begin
          state_d = S_ROUND;
        end else begin
          big_d = shl;
          exp_d = exp_dec;
          if (exp_dec == '0) begin
            fin = 1'b1; fin_res = {sign_q, {(W-1){1'b0}}};
            fin_unf = 1'b1; fin_inx = 1'b1;
          end else if (shl[MW-2]) begin
            state_d = S_ROUND;
          end
        end
      end
      S_ROUND: begin
        fin     = 1'b1;
        fin_ovf = rovf;
        fin_inx = g | r | s | rovf;
        fin_res = rovf ? {sign_q, EXP_ONES, {MAN_W{1'b0}}}
                       : {sign_q, rexp[EXP_W-1:0], rfrac};
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      state_d = S_DONE;
      res_d   = fin_res;
      inv_d   = fin_inv;
      ovf_d   = fin_ovf;
      unf_d   = fin_unf;
      inx_d   = fin_inx;
    end

    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_ALIGN) || (state_d == S_ADD) ||
             (state_d == S_NORM)  || (state_d == S_ROUND);
  end

  // State, datapath and registered outputs; reset discards any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      big_q   <= '0;
      small_q <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inx_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      exp_q   <= exp_d;
      big_q   <= big_d;
      small_q <= small_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inx_q   <= inx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign dataR          = res_q;
  assign flag_invalid   = inv_q;
  assign flag_overflow  = ovf_q;
  assign flag_underflow = unf_q;
  assign flag_inexact   = inx_q;

endmodule
